ila_capture_reader: RTL and testbench
=====================================

// Module: ila_capture_reader
// PURPOSE
// - Read-side counterpart to the in-RTL ILA probe instances. Samples a packed probe vector each clk into a circular RAM.
// - Arms, triggers on a masked compare, then captures a programmable post-trigger window.
// - Dumps the stored window oldest-first as a byte stream over valid/ready to the board debug UART/JTAG bridge.
// - Placed in the same `ifdef FPGA_ILA regions as the probe instances.
// PARAMETERS
// - PROBE_W  21   width of packed probe vector (e.g. six fields of 1..6 bits)
// - DEPTH    256  samples stored; power of two, >=4
// - TS_W     16   timestamp width; used only with ILA_TIMESTAMP_EN
// - derived: AW=$clog2(DEPTH); NB=ceil(PROBE_W/8); NT=ceil(TS_W/8)
// PORTS
// - clk         in   1        single clock for all logic
// - rst_n       in   1        asynchronous active-low reset
// - probe_in    in   PROBE_W  signals sampled every cycle
// - trig_mask   in   PROBE_W  1 = bit takes part in trigger compare
// - trig_value  in   PROBE_W  compare value
// - post_trig   in   AW       samples stored after trigger sample; latched at arm
// - arm         in   1        1-cycle pulse; starts capture from IDLE only
// - m_valid     out  1        dump byte valid
// - m_data      out  8        dump byte
// - m_last      out  1        final byte of dump
// - m_ready     in   1        sink accepts byte when m_valid&m_ready
// - busy        out  1        state != IDLE
// - triggered   out  1        trigger seen in current capture; held until next arm
// BEHAVIOUR
// - Reset: state=IDLE; m_valid=0, m_data=0, m_last=0, busy=0, triggered=0; wr_ptr=0, fill=0. RAM contents undefined.
// - States: IDLE -> PRE -> POST -> DUMP -> IDLE.
// - IDLE: arm=1 -> PRE. Latches post_trig; clears wr_ptr, fill, triggered.
// - PRE: writes probe_in at wr_ptr each cycle; wr_ptr wraps mod DEPTH; fill saturates at DEPTH.
//   - Hit = ((probe_in^trig_value)&trig_mask)==0. Hit sample is stored; then triggered=1 and state -> POST.
//   - Hit on first PRE cycle is legal (mask=0 triggers immediately).
// - POST: writes post_trig further samples, then -> DUMP.
//   - post_trig=0: DUMP the cycle after the hit.
//   - Oldest samples are overwritten if the total exceeds DEPTH.
// - DUMP: count = fill (<=DEPTH). Start address = wr_ptr if fill==DEPTH, else 0.
//   - Per sample: NB bytes of probe LSB-first, zero-padded in the top byte.
//   - RAM read latency is 1 cycle. Prefetch so m_valid is continuous while m_ready=1.
//   - m_data is held stable while m_valid=1 and m_ready=0.
//   - m_last=1 only with the final byte. That handshake -> IDLE (busy=0 next cycle).
// - arm outside IDLE: ignored. probe_in is not sampled in IDLE or DUMP.
// - Async reset mid-capture or mid-dump: outputs return to reset values immediately; no partial frame recovery.
// CONFIGURATION
// - ILA_TIMESTAMP_EN defined:
//   - TS_W counter clears on arm and increments every PRE/POST cycle.
//   - Each RAM word stores {ts,probe}. Dump emits NB probe bytes, then NT timestamp bytes LSB-first, per sample.
// - ILA_TIMESTAMP_EN undefined: no counter, RAM word is PROBE_W, TS_W ignored, NB bytes per sample.
// TESTING
// - Directed scenarios (PROBE_W=21, DEPTH=8, post_trig=2, ILA_TIMESTAMP_EN undefined unless stated):
// - Reset: rst_n=0 with random inputs -> m_valid=0, busy=0, triggered=0; arm ignored while reset asserted.
// - Immediate trigger: mask=0, arm, probe=ramp 0x10,0x11,... -> 3 samples, 9 bytes: 10 00 00 11 00 00 12 00 00; m_last on byte 9.
// - Wrap: mask=0x1FFFFF, value=20, ramp from 0, post_trig=2
//   -> hit at 20, samples 15..22 dumped oldest-first (8 samples, 24 bytes).
// - Backpressure: m_ready toggled 1-0-0-1 randomly during dump -> byte sequence identical to full-rate run; m_data stable while stalled.
// - Arm during DUMP and reset mid-DUMP: arm has no effect. rst_n pulse at byte 5 -> m_valid=0 at once; new arm after reset captures normally.
// - ILA_TIMESTAMP_EN, TS_W=16, immediate trigger -> per sample 3 probe bytes + 2 ts bytes; ts values 0,1,2.

Source files
------------

// File: rtl/ila_capture_reader_if.sv
// Dump byte-stream bundle for ila_capture_reader: valid/ready, one data byte, last flag.
// master drives m_valid/m_data/m_last and samples m_ready; slave is the reverse.
interface ila_capture_reader_if;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_last;
    logic       m_ready;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/ila_capture_reader.sv
// ILA capture reader: samples probe_in into a circular RAM once armed, triggers on
// a masked compare, keeps post_trig further samples, then dumps the window
// oldest-first as bytes over m (valid/ready/last).
// Ports: clk, rst_n (async, active low), probe_in, trig_mask, trig_value,
// post_trig (latched at arm), arm (pulse, IDLE only), m (master), busy, triggered.
// Optional: define ILA_TIMESTAMP_EN to store and dump a TS_W-bit cycle stamp per sample.
module ila_capture_reader #(
    parameter int PROBE_W = 21,
    parameter int DEPTH   = 256,
    parameter int TS_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PROBE_W-1:0]       probe_in,
    input  logic [PROBE_W-1:0]       trig_mask,
    input  logic [PROBE_W-1:0]       trig_value,
    input  logic [$clog2(DEPTH)-1:0] post_trig,
    input  logic                     arm,
    ila_capture_reader_if.master     m,
    output logic                     busy,
    output logic                     triggered
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = (PROBE_W + 7) / 8;
`ifdef ILA_TIMESTAMP_EN
    localparam int NT = (TS_W + 7) / 8;
    localparam int WW = PROBE_W + TS_W;
`else
    // Without timestamps the word is just the probe; TS_W has no effect.
    localparam int NT = 0;
    localparam int WW = PROBE_W + 0 * TS_W;
`endif
    localparam int BPS  = NB + NT;
    localparam int BW   = (BPS > 1) ? $clog2(BPS) : 1;
    localparam int PADW = 8 * BPS;

    localparam logic [AW:0]   FULL   = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   ONE_L  = (AW + 1)'(1);
    localparam logic [AW-1:0] ONE_C  = AW'(1);
    localparam logic [BW-1:0] LAST_B = BW'(BPS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PRE  = 2'd1;
    localparam logic [1:0] S_POST = 2'd2;
    localparam logic [1:0] S_DUMP = 2'd3;

    logic [1:0]    state_q,   state_d;
    logic [AW-1:0] wr_ptr_q,  wr_ptr_d;
    logic [AW:0]   fill_q,    fill_d;
    logic [AW-1:0] post_q,    post_d;
    logic [AW-1:0] cnt_q,     cnt_d;
    logic          trig_q,    trig_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [AW:0]   left_q,    left_d;
    logic [BW-1:0] bi_q,      bi_d;
    logic          mv_q,      mv_d;
`ifdef ILA_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;
`endif

    logic [WW-1:0]   mem [DEPTH];
    logic [WW-1:0]   rdata_q;
    logic [WW-1:0]   wdata;
    logic            we;
    logic            hit;
    logic            go_dump;
    logic [PADW-1:0] pad;

    assign hit = ((probe_in ^ trig_value) & trig_mask) == '0;
    assign we  = (state_q == S_PRE) || (state_q == S_POST);

`ifdef ILA_TIMESTAMP_EN
    assign wdata = {ts_q, probe_in};
`else
    assign wdata = probe_in;
`endif

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        fill_d    = fill_q;
        post_d    = post_q;
        cnt_d     = cnt_q;
        trig_d    = trig_q;
        rd_addr_d = rd_addr_q;
        left_d    = left_q;
        bi_d      = bi_q;
        mv_d      = mv_q;
        go_dump   = 1'b0;
`ifdef ILA_TIMESTAMP_EN
        ts_d      = ts_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d  = S_PRE;
                    post_d   = post_trig;
                    wr_ptr_d = '0;
                    fill_d   = '0;
                    trig_d   = 1'b0;
`ifdef ILA_TIMESTAMP_EN
                    ts_d     = '0;
`endif
                end
            end
            S_PRE, S_POST: begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (fill_q != FULL) begin
                    fill_d = fill_q + 1'b1;
                end
`ifdef ILA_TIMESTAMP_EN
                ts_d = ts_q + 1'b1;
`endif
                if (state_q == S_PRE) begin
                    if (hit) begin
                        trig_d = 1'b1;
                        cnt_d  = post_q;
                        if (post_q == '0) begin
                            go_dump = 1'b1;
                        end else begin
                            state_d = S_POST;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == ONE_C) begin
                        go_dump = 1'b1;
                    end
                end
                // Once the buffer has wrapped the oldest sample sits at the
                // next write slot; otherwise the window starts at 0.
                if (go_dump) begin
                    state_d   = S_DUMP;
                    rd_addr_d = (fill_d == FULL) ? wr_ptr_d : '0;
                    left_d    = fill_d;
                    bi_d      = '0;
                    mv_d      = 1'b0;
                end
            end
            S_DUMP: begin
                // First DUMP cycle only loads the first word; the read can't
                // overlap the final capture write that way.
                if (!mv_q) begin
                    mv_d = 1'b1;
                end else if (m.m_ready) begin
                    if (bi_q == LAST_B) begin
                        bi_d      = '0;
                        rd_addr_d = rd_addr_q + 1'b1;
                        left_d    = left_q - 1'b1;
                        if (left_q == ONE_L) begin
                            state_d = S_IDLE;
                            mv_d    = 1'b0;
                        end
                    end else begin
                        bi_d = bi_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                mv_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            post_q    <= '0;
            cnt_q     <= '0;
            trig_q    <= 1'b0;
            rd_addr_q <= '0;
            left_q    <= '0;
            bi_q      <= '0;
            mv_q      <= 1'b0;
`ifdef ILA_TIMESTAMP_EN
            ts_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            fill_q    <= fill_d;
            post_q    <= post_d;
            cnt_q     <= cnt_d;
            trig_q    <= trig_d;
            rd_addr_q <= rd_addr_d;
            left_q    <= left_d;
            bi_q      <= bi_d;
            mv_q      <= mv_d;
`ifdef ILA_TIMESTAMP_EN
            ts_q      <= ts_d;
`endif
        end
    end

    // Reading at the next address keeps rdata_q equal to mem[rd_addr_q],
    // so the next word is ready the cycle after the last byte of a sample.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_ptr_q] <= wdata;
        end
        rdata_q <= mem[rd_addr_d];
    end

    always_comb begin
        pad = '0;
        pad[PROBE_W-1:0] = rdata_q[PROBE_W-1:0];
`ifdef ILA_TIMESTAMP_EN
        pad[8*NB +: TS_W] = rdata_q[WW-1:PROBE_W];
`endif
    end

    assign m.m_valid = mv_q;
    assign m.m_data  = mv_q ? pad[8*int'(bi_q) +: 8] : 8'h00;
    assign m.m_last  = mv_q && (left_q == ONE_L) && (bi_q == LAST_B);
    assign busy      = state_q != S_IDLE;
    assign triggered = trig_q;

endmodule

// File: tb/tb_ila_capture_reader.sv
// Self-checking bench for ila_capture_reader (PROBE_W=21, DEPTH=8).
// Queue-based capture model plus literal byte-stream expectations.
module tb_ila_capture_reader;
    localparam int PW    = 21;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int TSW   = 16;
    localparam int NB    = 3;
`ifdef ILA_TIMESTAMP_EN
    localparam int NT = 2;
`else
    localparam int NT = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [PW-1:0] probe = '0;
    logic [PW-1:0] mask = '0;
    logic [PW-1:0] value = '0;
    logic [AW-1:0] post = '0;
    logic          arm = 1'b0;
    logic          busy;
    logic          triggered;

    ila_capture_reader_if bus ();

    ila_capture_reader #(
        .PROBE_W(PW),
        .DEPTH  (DEPTH),
        .TS_W   (TSW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .probe_in  (probe),
        .trig_mask (mask),
        .trig_value(value),
        .post_trig (post),
        .arm       (arm),
        .m         (bus),
        .busy      (busy),
        .triggered (triggered)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int            mstate = 0;
    bit            mtrig = 1'b0;
    int            mpost = 0;
    int            mrem = 0;
    int            mts = 0;
    logic [PW-1:0] sp[$];
    int            st[$];
    logic [7:0]    exp_q[$];
    logic [7:0]    got[$];
    logic [7:0]    lit[$];
    int            lasts = 0;
    bit            started = 1'b0;
    bit            pstall = 1'b0;
    logic [7:0]    pdata = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic mreset();
        mstate  = 0;
        mtrig   = 1'b0;
        started = 1'b0;
        pstall  = 1'b0;
        exp_q.delete();
        sp.delete();
        st.delete();
    endtask

    task automatic build();
        mstate = 3;
        exp_q.delete();
        for (int i = 0; i < sp.size(); i++) begin
            for (int b = 0; b < NB; b++) exp_q.push_back(8'(sp[i] >> (8 * b)));
            for (int b = 0; b < NT; b++) exp_q.push_back(8'(st[i] >> (8 * b)));
        end
    endtask

    // Capture model: stored window is the last DEPTH samples taken from the
    // cycle after arm up to hit + post_trig.
    always @(posedge clk) begin
        if (rst_n) begin
            case (mstate)
                0: if (arm) begin
                    mstate = 1;
                    mtrig  = 1'b0;
                    mts    = 0;
                    mpost  = int'(post);
                    sp.delete();
                    st.delete();
                end
                1, 2: begin
                    sp.push_back(probe);
                    st.push_back(mts);
                    mts++;
                    if (sp.size() > DEPTH) begin
                        void'(sp.pop_front());
                        void'(st.pop_front());
                    end
                    if (mstate == 1) begin
                        if (((probe ^ value) & mask) == '0) begin
                            mtrig = 1'b1;
                            mrem  = mpost;
                            if (mpost == 0) build();
                            else mstate = 2;
                        end
                    end else begin
                        mrem--;
                        if (mrem == 0) build();
                    end
                end
                3: if (exp_q.size() == 0) mstate = 0;
                default: mstate = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_valid", bus.m_valid, 0);
            chk("rst_data", bus.m_data, 0);
            chk("rst_last", bus.m_last, 0);
            chk("rst_busy", busy, 0);
            chk("rst_triggered", triggered, 0);
        end else begin
            chk("busy", busy, mstate != 0);
            chk("triggered", triggered, mtrig);
            if (bus.m_valid) begin
                if (mstate != 3 || exp_q.size() == 0) begin
                    chk("spurious_valid", bus.m_valid, 0);
                end else begin
                    if (pstall) chk("stall_data", bus.m_data, pdata);
                    started = 1'b1;
                    if (bus.m_ready) begin
                        chk("data", bus.m_data, exp_q[0]);
                        chk("last", bus.m_last, exp_q.size() == 1);
                        got.push_back(bus.m_data);
                        if (bus.m_last) lasts++;
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) started = 1'b0;
                    end
                end
            end else if (started) begin
                chk("continuous_valid", bus.m_valid, 1);
            end
            pstall = bus.m_valid && !bus.m_ready;
            pdata  = bus.m_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        arm = 1'b0;
        repeat (n) begin
            probe = PW'($urandom);
            bus.m_ready = 1'($urandom_range(0, 1));
            step();
        end
    endtask

    task automatic capture(input int start, input bit rnd_ready, input bit rnd_arm,
                           input bit rnd_probe, input int rst_at);
        int n;
        bit done;
        got.delete();
        lasts = 0;
        probe = rnd_probe ? PW'($urandom) : PW'(start - 1);
        arm = 1'b1;
        bus.m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        step();
        n = 0;
        done = 1'b0;
        while (!done) begin
            probe = rnd_probe ? PW'($urandom) : PW'(start + n);
            arm = rnd_arm ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            n++;
            if (rst_at > 0 && got.size() == rst_at - 1) begin
                rst_n = 1'b0;
                mreset();
                #1;
                chk("rst_mid_valid", bus.m_valid, 0);
                chk("rst_mid_busy", busy, 0);
                chk("rst_mid_last", bus.m_last, 0);
                arm = 1'b1;
                step();
                step();
                arm = 1'b0;
                rst_n = 1'b1;
                done = 1'b1;
            end else if (mstate == 0) begin
                done = 1'b1;
            end else if (n > 1000) begin
                checks++;
                failures++;
                $display("FAIL timeout: capture busy after %0d cycles, expected idle", n);
                done = 1'b1;
            end
        end
        arm = 1'b0;
    endtask

    task automatic cmp_lit(input string nm);
        chk({nm, "_len"}, got.size(), lit.size());
        for (int i = 0; i < lit.size() && i < got.size(); i++) chk({nm, "_byte"}, got[i], lit[i]);
        chk({nm, "_lasts"}, lasts, 1);
    endtask

    task automatic lit_imm();
`ifdef ILA_TIMESTAMP_EN
        lit = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h11, 8'h00, 8'h00, 8'h01, 8'h00,
                8'h12, 8'h00, 8'h00, 8'h02, 8'h00};
`else
        lit = '{8'h10, 8'h00, 8'h00, 8'h11, 8'h00, 8'h00, 8'h12, 8'h00, 8'h00};
`endif
    endtask

    task automatic lit_wrap();
        lit.delete();
        for (int v = 15; v <= 22; v++) begin
            lit.push_back(8'(v));
            lit.push_back(8'h00);
            lit.push_back(8'h00);
`ifdef ILA_TIMESTAMP_EN
            lit.push_back(8'(v));
            lit.push_back(8'h00);
`endif
        end
    endtask

    initial begin
        logic [PW-1:0] mk;
        bus.m_ready = 1'b0;
        mreset();
        #1;
        rst_n = 1'b0;
        repeat (6) begin
            probe = PW'($urandom);
            mask = PW'($urandom);
            value = PW'($urandom);
            post = AW'($urandom);
            arm = 1'b1;
            bus.m_ready = 1'($urandom_range(0, 1));
            step();
        end
        arm = 1'b0;
        rst_n = 1'b1;
        step();
        chk("arm_in_reset_busy", busy, 0);
        idle(3);

        mask = '0;
        post = 3'd2;
        capture(32'h10, 1'b0, 1'b0, 1'b0, 0);
        lit_imm();
        cmp_lit("immediate");
        idle(2);

        mask = '0;
        post = 3'd0;
        capture(32'h33, 1'b0, 1'b0, 1'b0, 0);
`ifdef ILA_TIMESTAMP_EN
        lit = '{8'h33, 8'h00, 8'h00, 8'h00, 8'h00};
`else
        lit = '{8'h33, 8'h00, 8'h00};
`endif
        cmp_lit("post0");
        idle(2);

        mask = 21'h1FFFFF;
        value = 21'd20;
        post = 3'd2;
        capture(0, 1'b0, 1'b0, 1'b0, 0);
        lit_wrap();
        cmp_lit("wrap");
        idle(2);

        capture(0, 1'b1, 1'b1, 1'b0, 0);
        cmp_lit("backpressure");
        idle(2);

        capture(0, 1'b0, 1'b0, 1'b0, 5);
        chk("rst_mid_bytes", got.size(), 4);
        idle(2);
        mask = '0;
        post = 3'd2;
        capture(32'h10, 1'b0, 1'b0, 1'b0, 0);
        lit_imm();
        cmp_lit("after_reset");
        idle(2);

        for (int it = 0; it < 30; it++) begin
            mk = '0;
            repeat ($urandom_range(0, 3)) mk[$urandom_range(0, PW - 1)] = 1'b1;
            mask = mk;
            value = PW'($urandom);
            post = AW'($urandom);
            capture(0, 1'b1, 1'b1, 1'b1, 0);
            chk("rand_lasts", lasts, 1);
            idle($urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
